// File: rtl/hdc_encode_ctrl_if.sv
// Sample-in / result-out handshake bundle for hdc_encode_ctrl.
// master = sample source plus result consumer, slave = the controller.
interface hdc_encode_ctrl_if #(
    parameter int NUM_FEATURES = 11,
    parameter int FEAT_W       = 32
);
    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_FEATURES*FEAT_W-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;

    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid);
endinterface

// File: rtl/hdc_encode_ctrl.sv
// IDLE/ENC/HOLD sequencer for the HDC encoder datapath.
// Defining ENC_CTRL_PERF_EN adds saturating completed-sample and HOLD-stall counters.
module hdc_encode_ctrl #(
    parameter int NUM_FEATURES = 11,
    parameter int FEAT_W       = 32,
    parameter int ENC_LAT      = 1,
    parameter int IDX_W        = 16
) (
    input  logic                           clk,
    input  logic                           nrst,
    hdc_encode_ctrl_if.slave               bus,
    input  logic                           abort,
    output logic [NUM_FEATURES*FEAT_W-1:0] enc_input_value,
    output logic                           enc_en,
    output logic [IDX_W-1:0]               sample_idx,
    output logic                           busy,
    output logic [31:0]                    perf_samples,
    output logic [31:0]                    perf_stall
);
    localparam int DW    = NUM_FEATURES * FEAT_W;
    localparam int LAT_W = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ENC, HOLD} state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DW-1:0]     data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              en_q, en_d, ov_q, ov_d, rdy_q, rdy_d, busy_q, busy_d;
    logic              in_ready_w, hs_in;

    // in_ready is registered except in HOLD, where it follows out_ready so a
    // result and the next sample can swap in the same cycle.
    assign in_ready_w = (state_q == HOLD) ? (bus.out_ready && !abort) : rdy_q;
    assign hs_in      = bus.in_valid && in_ready_w && !abort;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        data_d  = data_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (hs_in) state_d = ENC;
            ENC: begin
                if (abort)              state_d = IDLE;
                else if (lat_q == '0)   state_d = HOLD;
                else                    lat_d   = lat_q - 1'b1;
            end
            HOLD: begin
                if (abort)              state_d = IDLE;
                else if (bus.out_ready) state_d = hs_in ? ENC : IDLE;
            end
            default:                    state_d = IDLE;
        endcase
        if (hs_in) begin
            data_d = bus.in_data;
            idx_d  = idx_q + 1'b1;
            lat_d  = LAT_W'(ENC_LAT - 1);
        end
        en_d   = (state_d == ENC);
        ov_d   = (state_d == HOLD);
        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == IDLE);
    end

    // Index resets to all-ones so the first accepted sample reads 0.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            data_q  <= '0;
            idx_q   <= '1;
            en_q    <= 1'b0;
            ov_q    <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            ov_q    <= ov_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = ov_q;
    assign enc_input_value = data_q;
    assign enc_en          = en_q;
    assign sample_idx      = idx_q;
    assign busy            = busy_q;

`ifdef ENC_CTRL_PERF_EN
    logic        hs_out;
    logic [31:0] perf_samples_q, perf_samples_d, perf_stall_q, perf_stall_d;

    assign hs_out = (state_q == HOLD) && bus.out_ready && !abort;

    always_comb begin
        perf_samples_d = perf_samples_q;
        perf_stall_d   = perf_stall_q;
        if (hs_out && perf_samples_q != '1)
            perf_samples_d = perf_samples_q + 32'd1;
        if (state_q == HOLD && !bus.out_ready && perf_stall_q != '1)
            perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            perf_samples_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_samples_q <= perf_samples_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_samples = perf_samples_q;
    assign perf_stall   = perf_stall_q;
`else
    assign perf_samples = '0;
    assign perf_stall   = '0;
`endif
endmodule

// File: tb/tb_hdc_encode_ctrl.sv
// Bench for hdc_encode_ctrl: DUT 0 (ENC_LAT=1, IDX_W=2) and DUT 1 (ENC_LAT=3, IDX_W=16)
// share one stimulus stream and are checked against a sample-age reference model.
module tb_hdc_encode_ctrl;
    localparam int NF = 11;
    localparam int FW = 32;
    localparam int DW = NF * FW;

    logic clk = 1'b0;
    logic nrst, in_valid, out_ready, abort;
    logic [DW-1:0] in_data;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hdc_encode_ctrl_if #(.NUM_FEATURES(NF), .FEAT_W(FW)) ifa ();
    hdc_encode_ctrl_if #(.NUM_FEATURES(NF), .FEAT_W(FW)) ifb ();
    assign ifa.in_valid = in_valid;  assign ifa.in_data = in_data;  assign ifa.out_ready = out_ready;
    assign ifb.in_valid = in_valid;  assign ifb.in_data = in_data;  assign ifb.out_ready = out_ready;

    logic          en [2];
    logic          bz [2];
    logic          ov [2];
    logic          ir [2];
    logic [DW-1:0] eiv [2];
    logic [15:0]   sid [2];
    logic [31:0]   pss [2];
    logic [31:0]   pst [2];
    logic [1:0]    sid_a;
    logic [15:0]   sid_b;

    hdc_encode_ctrl #(.NUM_FEATURES(NF), .FEAT_W(FW), .ENC_LAT(1), .IDX_W(2)) dut_a (
        .clk(clk), .nrst(nrst), .bus(ifa), .abort(abort), .enc_input_value(eiv[0]),
        .enc_en(en[0]), .sample_idx(sid_a), .busy(bz[0]), .perf_samples(pss[0]), .perf_stall(pst[0]));
    hdc_encode_ctrl #(.NUM_FEATURES(NF), .FEAT_W(FW), .ENC_LAT(3), .IDX_W(16)) dut_b (
        .clk(clk), .nrst(nrst), .bus(ifb), .abort(abort), .enc_input_value(eiv[1]),
        .enc_en(en[1]), .sample_idx(sid_b), .busy(bz[1]), .perf_samples(pss[1]), .perf_stall(pst[1]));

    assign sid[0] = {14'b0, sid_a};
    assign sid[1] = sid_b;
    assign ir[0] = ifa.in_ready;  assign ov[0] = ifa.out_valid;
    assign ir[1] = ifb.in_ready;  assign ov[1] = ifb.out_valid;

    // Reference model: age = cycles since the current sample was accepted
    // (0 = none). Encoding while age in 1..LAT, result held once age > LAT.
    int            age [2];
    int            idx [2];
    int            mps [2];
    int            mst [2];
    logic [DW-1:0] mdat [2];
    bit            mrdy [2];

    function automatic int lat(int m);  return (m == 0) ? 1 : 3;     endfunction
    function automatic int msk(int m);  return (m == 0) ? 3 : 65535; endfunction
    function automatic bit m_ir(int m);
        if (age[m] == 0) return mrdy[m];
        if (age[m] > lat(m)) return out_ready && !abort;
        return 1'b0;
    endfunction
    function automatic logic [31:0] e_ps(int m);
`ifdef ENC_CTRL_PERF_EN
        return 32'(mps[m]);
`else
        return (m < 0) ? 32'(mps[0]) : 32'd0;
`endif
    endfunction
    function automatic logic [31:0] e_st(int m);
`ifdef ENC_CTRL_PERF_EN
        return 32'(mst[m]);
`else
        return (m < 0) ? 32'(mst[0]) : 32'd0;
`endif
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!nrst) begin
                age[m] <= 0; idx[m] <= msk(m); mdat[m] <= '0; mrdy[m] <= 1'b0;
                mps[m] <= 0; mst[m] <= 0;
            end else begin
                mrdy[m] <= 1'b1;
                if (age[m] > lat(m) && out_ready && !abort) mps[m] <= mps[m] + 1;
                if (age[m] > lat(m) && !out_ready) mst[m] <= mst[m] + 1;
                if (abort && age[m] != 0) age[m] <= 0;
                else if (in_valid && m_ir(m) && !abort) begin
                    age[m] <= 1; idx[m] <= (idx[m] + 1) & msk(m); mdat[m] <= in_data;
                end else if (age[m] > lat(m)) begin
                    if (out_ready) age[m] <= 0;
                end else if (age[m] != 0) age[m] <= age[m] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic rand_data();
        for (int k = 0; k < NF; k++) in_data[k*FW +: FW] = $urandom;
    endtask

    task automatic test_reset();
        nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0; in_data = '0;
        tick(); tick();
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (en[m] !== 1'b0) begin n_fail++; $display("FAIL reset_en dut%0d got %0b want 0", m, en[m]); end
            n_chk++; if (ov[m] !== 1'b0) begin n_fail++; $display("FAIL reset_ov dut%0d got %0b want 0", m, ov[m]); end
            n_chk++; if (bz[m] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d got %0b want 0", m, bz[m]); end
            n_chk++; if (ir[m] !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready dut%0d got %0b want 0", m, ir[m]); end
            n_chk++; if (eiv[m] !== '0) begin n_fail++; $display("FAIL reset_eiv dut%0d got %h want 0", m, eiv[m]); end
            n_chk++; if (sid[m] !== 16'(msk(m))) begin n_fail++; $display("FAIL reset_idx dut%0d got %0d want %0d", m, sid[m], msk(m)); end
            n_chk++; if (pss[m] !== 32'd0 || pst[m] !== 32'd0) begin n_fail++; $display("FAIL reset_perf dut%0d got %0d/%0d want 0/0", m, pss[m], pst[m]); end
        end
        nrst = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (ir[m] !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready dut%0d got %0b want 1", m, ir[m]); end
        end
    endtask

    // Single sample on DUT 0, then 5 cycles of backpressure while it holds.
    task automatic test_single_backpressure();
        logic [DW-1:0] pat;
        do_reset();
        for (int k = 0; k < NF; k++) pat[k*FW +: FW] = 32'(k + 1);
        in_data = pat; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; rand_data();
        n_chk++; if (en[0] !== 1'b1 || ov[0] !== 1'b0) begin n_fail++; $display("FAIL single_c1 en/ov got %0b/%0b want 1/0", en[0], ov[0]); end
        n_chk++; if (en[1] !== 1'b1) begin n_fail++; $display("FAIL single_c1_lat3 en got %0b want 1", en[1]); end
        n_chk++; if (sid[0] !== 16'd0) begin n_fail++; $display("FAIL single_idx got %0d want 0", sid[0]); end
        n_chk++; if (eiv[0] !== pat) begin n_fail++; $display("FAIL single_eiv got %h want %h", eiv[0], pat); end
        tick();
        n_chk++; if (en[0] !== 1'b0 || ov[0] !== 1'b1) begin n_fail++; $display("FAIL single_c2 en/ov got %0b/%0b want 0/1", en[0], ov[0]); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; rand_data();
            #1;
            n_chk++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d got %0b want 0", i, ir[0]); end
            n_chk++; if (ov[0] !== 1'b1 || en[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ov_en cyc%0d got %0b/%0b want 1/0", i, ov[0], en[0]); end
            n_chk++; if (eiv[0] !== pat) begin n_fail++; $display("FAIL bp_eiv cyc%0d got %h want %h", i, eiv[0], pat); end
            tick();
        end
        n_chk++; if (pst[0] !== e_st(0) || e_st(0) !== pst[0] || (e_st(0) != 0 && pst[0] !== 32'd5)) begin
            n_fail++; $display("FAIL bp_perf_stall got %0d want %0d", pst[0], e_st(0)); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_chk++; if (ov[0] !== 1'b0 || bz[0] !== 1'b0) begin n_fail++; $display("FAIL bp_release ov/busy got %0b/%0b want 0/0", ov[0], bz[0]); end
        n_chk++; if (pss[0] !== e_ps(0)) begin n_fail++; $display("FAIL bp_perf_samples got %0d want %0d", pss[0], e_ps(0)); end
        n_chk++; if (eiv[0] !== pat) begin n_fail++; $display("FAIL bp_eiv_after got %h want %h", eiv[0], pat); end
    endtask

    // Streaming with in_valid/out_ready high: DUT 1 cycles every 4, DUT 0 every 2 (idx wraps at 4).
    task automatic test_back_to_back();
        do_reset();
        rand_data(); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            rand_data();
            n_chk++; if (en[1] !== (c % 4 != 0)) begin n_fail++; $display("FAIL b2b_en_lat3 c%0d got %0b want %0b", c, en[1], c % 4 != 0); end
            n_chk++; if (ov[1] !== (c % 4 == 0)) begin n_fail++; $display("FAIL b2b_ov_lat3 c%0d got %0b want %0b", c, ov[1], c % 4 == 0); end
            n_chk++; if (sid[1] !== 16'((c - 1) / 4)) begin n_fail++; $display("FAIL b2b_idx_lat3 c%0d got %0d want %0d", c, sid[1], (c - 1) / 4); end
            n_chk++; if (en[0] !== (c % 2 == 1) || ov[0] !== (c % 2 == 0)) begin n_fail++; $display("FAIL b2b_en_ov_lat1 c%0d got %0b/%0b", c, en[0], ov[0]); end
            n_chk++; if (sid[0] !== 16'(((c - 1) / 2) % 4)) begin n_fail++; $display("FAIL b2b_idx_wrap c%0d got %0d want %0d", c, sid[0], ((c - 1) / 2) % 4); end
            for (int m = 0; m < 2; m++) begin
                n_chk++; if (eiv[m] !== mdat[m]) begin n_fail++; $display("FAIL b2b_eiv dut%0d c%0d got %h want %h", m, c, eiv[m], mdat[m]); end
            end
            if (c == 16) in_valid = 1'b0;
            tick();
        end
    endtask

    // Abort in DUT 1's second ENC cycle, which is also DUT 0's HOLD cycle with out_ready=1.
    task automatic test_abort();
        do_reset();
        rand_data(); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        abort = 1'b1;
        #1;
        n_chk++; if (ir[0] !== 1'b0 || ir[1] !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready got %0b/%0b want 0/0", ir[0], ir[1]); end
        n_chk++; if (ov[0] !== 1'b1 || en[1] !== 1'b1) begin n_fail++; $display("FAIL abort_pre_state ov0/en1 got %0b/%0b want 1/1", ov[0], en[1]); end
        tick();
        abort = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (en[m] !== 1'b0 || ov[m] !== 1'b0 || bz[m] !== 1'b0) begin n_fail++; $display("FAIL abort_idle dut%0d en/ov/busy %0b/%0b/%0b want 0/0/0", m, en[m], ov[m], bz[m]); end
        end
        n_chk++; if (pss[0] !== 32'd0) begin n_fail++; $display("FAIL abort_no_handshake perf_samples got %0d want 0", pss[0]); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin n_fail++; $display("FAIL abort_no_ov cyc%0d got %0b/%0b", i, ov[0], ov[1]); end
        end
        abort = 1'b1; in_valid = 1'b1;
        tick();
        abort = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (bz[m] !== 1'b0 || sid[m] !== 16'd0) begin n_fail++; $display("FAIL abort_idle_ignored dut%0d busy/idx %0b/%0d want 0/0", m, bz[m], sid[m]); end
        end
        tick();
        in_valid = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (sid[m] !== 16'd1 || en[m] !== 1'b1) begin n_fail++; $display("FAIL abort_next_idx dut%0d idx/en %0d/%0b want 1/1", m, sid[m], en[m]); end
        end
    endtask

    task automatic test_reset_mid_enc();
        do_reset();
        rand_data(); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; nrst = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (en[m] !== 1'b0 || ov[m] !== 1'b0 || bz[m] !== 1'b0 || ir[m] !== 1'b0) begin
                n_fail++; $display("FAIL midreset_ctl dut%0d en/ov/busy/rdy %0b/%0b/%0b/%0b want 0", m, en[m], ov[m], bz[m], ir[m]); end
            n_chk++; if (eiv[m] !== '0 || sid[m] !== 16'(msk(m))) begin
                n_fail++; $display("FAIL midreset_data dut%0d idx %0d want %0d eiv %h", m, sid[m], msk(m), eiv[m]); end
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rand_data();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            abort     = ($urandom_range(0, 19) == 0);
            nrst      = ($urandom_range(0, 99) != 0);
            #1;
            for (int m = 0; m < 2; m++) begin
                n_chk++; if (ir[m] !== m_ir(m)) begin n_fail++; $display("FAIL rnd_in_ready dut%0d i%0d got %0b want %0b", m, i, ir[m], m_ir(m)); end
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                n_chk++;
                if (en[m] !== (age[m] >= 1 && age[m] <= lat(m)) || ov[m] !== (age[m] > lat(m)) || bz[m] !== (age[m] != 0)) begin
                    n_fail++; $display("FAIL rnd_ctl dut%0d i%0d en/ov/busy %0b/%0b/%0b age %0d", m, i, en[m], ov[m], bz[m], age[m]); end
                n_chk++; if (sid[m] !== 16'(idx[m])) begin n_fail++; $display("FAIL rnd_idx dut%0d i%0d got %0d want %0d", m, i, sid[m], idx[m]); end
                n_chk++; if (eiv[m] !== mdat[m]) begin n_fail++; $display("FAIL rnd_eiv dut%0d i%0d got %h want %h", m, i, eiv[m], mdat[m]); end
                n_chk++; if (pss[m] !== e_ps(m) || pst[m] !== e_st(m)) begin
                    n_fail++; $display("FAIL rnd_perf dut%0d i%0d got %0d/%0d want %0d/%0d", m, i, pss[m], pst[m], e_ps(m), e_st(m)); end
            end
        end
        nrst = 1'b1; abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_backpressure();
        test_back_to_back();
        test_abort();
        test_reset_mid_enc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
